// File: rtl/selector_rr_scheduler_if.sv
// Bus between the round-robin scheduler, its 8 requesters and the shared
// 8:1 byte selector. The master side is the scheduler. The slave side is the
// requesters together with the selector.
interface selector_rr_scheduler_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        req;
    logic [DATA_W-1:0] sel_data;
    logic [2:0]        choice;
    logic [7:0]        grant;
    logic              grant_valid;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;

    modport master (
        input  req,
        input  sel_data,
        output choice,
        output grant,
        output grant_valid,
        output data_out,
        output data_valid
    );

    modport slave (
        output req,
        output sel_data,
        input  choice,
        input  grant,
        input  grant_valid,
        input  data_out,
        input  data_valid
    );
endinterface

// File: rtl/selector_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 byte selector among 8 requesters.
// - Each grant is one-hot and lasts at most SLOT_CYCLES cycles.
// - After a release, the priority pointer moves to the slot just past the
//   releasing requester, and arbitration runs again in the same cycle.
//   Because of this, consecutive grants follow each other with no idle gap.
// - Every output comes from a register, so there is no combinational path
//   from req to any output.
module selector_rr_scheduler #(
    parameter int DATA_W      = 8,
    parameter int SLOT_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    selector_rr_scheduler_if.master  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] SLOT_LAST = 4'(SLOT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        grant_q, grant_d;
    logic [2:0]        choice_q, choice_d;
    logic [3:0]        slot_q, slot_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_q;

    logic [2:0]        arb_ptr;
    logic [2:0]        arb_win;
    logic              arb_found;
    logic              release_now;

    // Circular priority scan: take the first active request found when
    // scanning upward from arb_ptr and wrapping modulo 8.
    always_comb begin
        logic [2:0] idx;
        arb_found = 1'b0;
        arb_win   = 3'd0;
        idx       = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = arb_ptr + 3'(k);
            if (!arb_found && bus.req[idx]) begin
                arb_found = 1'b1;
                arb_win   = idx;
            end
        end
    end

    // State register together with the registered datapath. Reset takes
    // priority and aborts any grant in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 8'd0;
            choice_q     <= 3'd0;
            slot_q       <= 4'd0;
            ptr_q        <= 3'd0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            choice_q     <= choice_d;
            slot_q       <= slot_d;
            ptr_q        <= ptr_d;
            data_valid_q <= (state_q == GRANT);
            if (state_q == GRANT) begin
                data_out_q <= bus.sel_data;
            end
        end
    end

    // Next-state logic. A grant is released when its owner drops req or
    // when its slot expires. On release, arbitration uses the advanced
    // pointer, so a lone requester may win again right away.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        choice_d    = choice_q;
        slot_d      = slot_q;
        ptr_d       = ptr_q;
        arb_ptr     = ptr_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d  = 8'b1 << arb_win;
                    choice_d = arb_win;
                    slot_d   = 4'd0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                arb_ptr     = choice_q + 3'd1;
                release_now = !bus.req[choice_q] || (slot_q == SLOT_LAST);
                if (!release_now) begin
                    slot_d = slot_q + 4'd1;
                end else begin
                    ptr_d = choice_q + 3'd1;
                    if (arb_found) begin
                        grant_d  = 8'b1 << arb_win;
                        choice_d = arb_win;
                        slot_d   = 4'd0;
                    end else begin
                        grant_d = 8'd0;
                        slot_d  = 4'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'd0;
            end
        endcase
    end

    // Output decode. Every value here is taken directly from a register.
    always_comb begin
        bus.grant       = grant_q;
        bus.choice      = choice_q;
        bus.grant_valid = (state_q == GRANT);
        bus.data_out    = data_out_q;
        bus.data_valid  = data_valid_q;
    end

endmodule

// File: tb/tb_selector_rr_scheduler.sv
// Directed bench for selector_rr_scheduler. The selector is modelled as
// sel_data = 0x30 + choice, which makes every registered byte identify the
// requester that was selected.
module tb_selector_rr_scheduler;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    selector_rr_scheduler_if #(.DATA_W(8)) bus ();

    selector_rr_scheduler #(
        .DATA_W(8),
        .SLOT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    assign bus.sel_data = 8'h30 + {5'd0, bus.choice};

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply a one-cycle reset with every request low.
    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 8'h00;
        step();
        rst_n = 1'b1;
    endtask

    // Hold reset with every request raised, then check that the first
    // grant goes to requester 0.
    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (bus.grant !== 8'h00) begin
                bad++;
                $display("[TB] FAIL reset_grant cyc=%0d got=%h want=00", c, bus.grant);
            end
            total++;
            if (bus.choice !== 3'd0) begin
                bad++;
                $display("[TB] FAIL reset_choice cyc=%0d got=%0d want=0", c, bus.choice);
            end
            total++;
            if (bus.data_valid !== 1'b0 || bus.grant_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_valid cyc=%0d got dv=%b gv=%b want 0/0", c, bus.data_valid, bus.grant_valid);
            end
        end
        rst_n = 1'b1;
        step();
        total++;
        if (bus.grant !== 8'h01 || bus.choice !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_first_grant got=%h/%0d want=01/0", bus.grant, bus.choice);
        end
    endtask

    // A single requester is re-granted back-to-back with no gap, and
    // data_out trails the selector by one cycle.
    task automatic test_single();
        do_reset();
        bus.req = 8'h10;
        for (int e = 1; e <= 9; e++) begin
            step();
            total++;
            if (bus.grant !== 8'h10 || bus.choice !== 3'd4 || bus.grant_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL single_grant e=%0d got=%h/%0d/%b want=10/4/1", e, bus.grant, bus.choice, bus.grant_valid);
            end
            total++;
            if (e == 1) begin
                if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin
                    bad++;
                    $display("[TB] FAIL single_data_first got=%b/%h want=0/00", bus.data_valid, bus.data_out);
                end
            end else if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h34) begin
                bad++;
                $display("[TB] FAIL single_data e=%0d got=%b/%h want=1/34", e, bus.data_valid, bus.data_out);
            end
        end
    endtask

    // With requesters 0 and 7 both active, grants alternate 0, 7, 0 for
    // four cycles each, and the pointer wraps from 7 back to 0.
    task automatic test_wrap();
        int         exp_ch[12];
        logic [7:0] exp_g;
        exp_ch = '{0, 0, 0, 0, 7, 7, 7, 7, 0, 0, 0, 0};
        do_reset();
        bus.req = 8'h81;
        for (int e = 0; e < 12; e++) begin
            step();
            exp_g = 8'b1 << exp_ch[e];
            total++;
            if (bus.grant !== exp_g || bus.choice !== 3'(exp_ch[e])) begin
                bad++;
                $display("[TB] FAIL wrap_grant e=%0d got=%h/%0d want=%h/%0d", e, bus.grant, bus.choice, exp_g, exp_ch[e]);
            end
            if (e > 0) begin
                total++;
                if (bus.data_out !== 8'(8'h30 + exp_ch[e-1]) || bus.data_valid !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL wrap_data e=%0d got=%h/%b want=%h/1", e, bus.data_out, bus.data_valid, 8'(8'h30 + exp_ch[e-1]));
                end
            end
        end
    endtask

    // Requester 1 drops early and the grant moves to 2 at the next edge.
    // The following release starts the scan at 3 and wraps around to 1.
    task automatic test_early_drop();
        do_reset();
        bus.req = 8'h06;
        step();
        step();
        total++;
        if (bus.grant !== 8'h02 || bus.choice !== 3'd1) begin
            bad++;
            $display("[TB] FAIL drop_first got=%h/%0d want=02/1", bus.grant, bus.choice);
        end
        bus.req = 8'h04;
        step();
        total++;
        if (bus.grant !== 8'h04 || bus.choice !== 3'd2) begin
            bad++;
            $display("[TB] FAIL drop_move got=%h/%0d want=04/2", bus.grant, bus.choice);
        end
        for (int e = 0; e < 3; e++) begin
            step();
            total++;
            if (bus.grant !== 8'h04) begin
                bad++;
                $display("[TB] FAIL drop_hold e=%0d got=%h want=04", e, bus.grant);
            end
        end
        bus.req = 8'h06;
        step();
        total++;
        if (bus.grant !== 8'h02 || bus.choice !== 3'd1) begin
            bad++;
            $display("[TB] FAIL drop_ptr_wrap got=%h/%0d want=02/1", bus.grant, bus.choice);
        end
    endtask

    // A reset in the middle of a grant clears the grant and the pointer,
    // so arbitration starts again from index 0.
    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 8'h24;
        for (int e = 0; e < 5; e++) begin
            step();
        end
        total++;
        if (bus.grant !== 8'h20 || bus.choice !== 3'd5) begin
            bad++;
            $display("[TB] FAIL midrst_pre got=%h/%0d want=20/5", bus.grant, bus.choice);
        end
        step();
        rst_n = 1'b0;
        step();
        total++;
        if (bus.grant !== 8'h00 || bus.choice !== 3'd0 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin
            bad++;
            $display("[TB] FAIL midrst_clear got=%h/%0d/%b/%h want=00/0/0/00", bus.grant, bus.choice, bus.data_valid, bus.data_out);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (bus.grant !== 8'h04 || bus.choice !== 3'd2) begin
            bad++;
            $display("[TB] FAIL midrst_restart got=%h/%0d want=04/2", bus.grant, bus.choice);
        end
    endtask

    // A one-cycle request gives a single one-cycle grant, then the block
    // returns to idle. data_valid pulses once, one cycle after the grant.
    task automatic test_idle_return();
        do_reset();
        bus.req = 8'h08;
        step();
        total++;
        if (bus.grant !== 8'h08 || bus.choice !== 3'd3 || bus.data_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_grant got=%h/%0d/%b want=08/3/0", bus.grant, bus.choice, bus.data_valid);
        end
        bus.req = 8'h00;
        step();
        total++;
        if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_release got=%h/%b want=00/0", bus.grant, bus.grant_valid);
        end
        total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h33) begin
            bad++;
            $display("[TB] FAIL idle_data_pulse got=%b/%h want=1/33", bus.data_valid, bus.data_out);
        end
        step();
        total++;
        if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h33 || bus.grant !== 8'h00) begin
            bad++;
            $display("[TB] FAIL idle_after got=%b/%h/%h want=0/33/00", bus.data_valid, bus.data_out, bus.grant);
        end
    endtask

    // Run every scenario in order, then print the summary line.
    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        $display("[TB] starting selector_rr_scheduler bench");
        test_reset();
        test_single();
        test_wrap();
        test_early_drop();
        test_reset_mid_grant();
        test_idle_return();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
